// File: rtl/apb_regfile_slave.sv
// -----------------------------------------------------------------------------
// apb_regfile_slave
//
// APB completer backed by a bank of NUM_REGS 32-bit read/write registers.
// Every transfer is decoded on its setup phase. The slave then stretches the
// access phase by WAIT_STATES cycles and completes with a one-cycle pready.
// An access is an error when the byte address is not word aligned or the word
// index is outside the bank. A successful write commits at the edge that ends
// the pready cycle. A one-cycle wr_pulse follows in the next cycle. Register 0
// is exported as ctrl_out.
//
// Parameters
//   NUM_REGS     number of 32-bit registers (1..256)
//   WAIT_STATES  wait cycles inserted per transfer (0..15)
//
// Ports
//   clk       in   rising-edge clock
//   reset_n   in   asynchronous active-low reset
//   psel      in   slave select
//   penable   in   access phase
//   pwrite    in   1 = write, 0 = read
//   paddr     in   32-bit byte address
//   pwdata    in   32-bit write data
//   prdata    out  read data, valid while pready = 1, otherwise 0
//   pready    out  transfer completes in this cycle
//   pslverr   out  error response, valid while pready = 1, otherwise 0
//   ctrl_out  out  current value of register 0
//   wr_pulse  out  high for one cycle after a write commits
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module apb_regfile_slave #(
    parameter int NUM_REGS    = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic [31:0] ctrl_out,
    output logic        wr_pulse
);

    localparam int          IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [3:0]  WAIT_LOAD  = 4'(WAIT_STATES);
    localparam logic [29:0] NUM_REGS_W = 30'(NUM_REGS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    // The address is bad if it is misaligned or past the end of the bank.
    function automatic logic addr_error(input logic [31:0] addr);
        addr_error = (addr[1:0] != 2'b00) || (addr[31:2] >= NUM_REGS_W);
    endfunction

    // FSM and wait counter
    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;

    // Transfer attributes captured on the setup phase
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              write_q, write_d;
    logic              err_q, err_d;
    logic [31:0]       wdata_q, wdata_d;

    // Register bank
    logic [31:0]       regs_q [NUM_REGS];
    logic [31:0]       regs_d [NUM_REGS];

    // Registered outputs
    logic [31:0]       prdata_q, prdata_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;
    logic              wr_pulse_q, wr_pulse_d;

    // Combinational helpers
    logic              setup_s;
    logic [IDX_W-1:0]  cur_idx_s;
    logic              cur_write_s;
    logic              cur_err_s;
    logic              commit_s;

    // Setup-phase detect. This block also selects the attributes of the
    // transfer that is about to enter READY. With zero wait states, READY is
    // entered straight from IDLE, so the live bus values must be used in
    // that case. Otherwise the latched copies are used.
    always_comb begin
        setup_s = psel & ~penable;
        if (state_q == ST_IDLE) begin
            cur_idx_s   = paddr[IDX_W+1:2];
            cur_write_s = pwrite;
            cur_err_s   = addr_error(paddr);
        end else begin
            cur_idx_s   = idx_q;
            cur_write_s = write_q;
            cur_err_s   = err_q;
        end
    end

    // FSM state register and wait counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. The counter is loaded with WAIT_STATES and counts
    // down once per WAIT cycle. WAIT exits when the count would reach zero,
    // which gives exactly WAIT_STATES cycles in WAIT. Dropping psel during
    // the access phase abandons the transfer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (setup_s) begin
                    if (WAIT_STATES == 0) begin
                        state_d = ST_READY;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end
            end
            ST_WAIT: begin
                if (!psel) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q <= 4'd1) begin
                    state_d = ST_READY;
                    cnt_d   = 4'd0;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            ST_READY: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Output and datapath logic. This block does three things:
    // - It captures the transfer on its setup phase.
    // - It commits a good write at the end of READY, if psel is still high.
    // - It prepares the response flops so that they hold data only in the
    //   cycle where pready is high.
    always_comb begin
        if ((state_q == ST_IDLE) && setup_s) begin
            idx_d   = paddr[IDX_W+1:2];
            write_d = pwrite;
            err_d   = addr_error(paddr);
            wdata_d = pwdata;
        end else begin
            idx_d   = idx_q;
            write_d = write_q;
            err_d   = err_q;
            wdata_d = wdata_q;
        end

        commit_s = (state_q == ST_READY) && psel && write_q && !err_q;

        regs_d = regs_q;
        if (commit_s) begin
            regs_d[idx_q] = wdata_q;
        end else begin
            regs_d = regs_q;
        end
        wr_pulse_d = commit_s;

        pready_d = (state_d == ST_READY);
        if (pready_d) begin
            pslverr_d = cur_err_s;
            if (!cur_write_s && !cur_err_s) begin
                prdata_d = regs_q[cur_idx_s];
            end else begin
                prdata_d = 32'h0000_0000;
            end
        end else begin
            pslverr_d = 1'b0;
            prdata_d  = 32'h0000_0000;
        end
    end

    // Register bank, captured transfer attributes and response flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 32'h0000_0000;
            end
            idx_q      <= '0;
            write_q    <= 1'b0;
            err_q      <= 1'b0;
            wdata_q    <= 32'h0000_0000;
            prdata_q   <= 32'h0000_0000;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            wr_pulse_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            idx_q      <= idx_d;
            write_q    <= write_d;
            err_q      <= err_d;
            wdata_q    <= wdata_d;
            prdata_q   <= prdata_d;
            pready_q   <= pready_d;
            pslverr_q  <= pslverr_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    assign prdata   = prdata_q;
    assign pready   = pready_q;
    assign pslverr  = pslverr_q;
    assign wr_pulse = wr_pulse_q;
    assign ctrl_out = regs_q[0];

endmodule

// File: tb/tb_apb_regfile_slave.sv
// -----------------------------------------------------------------------------
// Testbench for apb_regfile_slave.
//
// Two instances are used: one with no wait states and one with three. The
// reference model is a plain array of register values. When a transfer is
// issued, the expected response is queued together with the cycle in which
// pready must appear. A committing write also queues the wr_pulse cycle and
// the new value of register 0. A monitor running on the falling edge pops
// these expectations and compares them against both instances.
// -----------------------------------------------------------------------------
module tb_apb_regfile_slave;

    localparam int NREG = 8;
    localparam int WS0  = 0;
    localparam int WS1  = 3;

    logic        clk = 1'b0;
    logic        rst_n     [2];
    logic        psel      [2];
    logic        penable   [2];
    logic        pwrite    [2];
    logic [31:0] paddr     [2];
    logic [31:0] pwdata    [2];
    logic [31:0] prdata_o  [2];
    logic        pready_o  [2];
    logic        pslverr_o [2];
    logic [31:0] ctrl_o    [2];
    logic        wr_pulse_o[2];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int          d;
        int          cyc;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    typedef struct {
        int          d;
        int          cyc;
        logic [31:0] ctrl;
    } pls_t;

    rsp_t        rq[$];
    pls_t        pq[$];
    logic [31:0] mem      [2][NREG];
    logic [31:0] ctrl_exp [2];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    apb_regfile_slave #(.NUM_REGS(NREG), .WAIT_STATES(WS0)) u_dut0 (
        .clk(clk), .reset_n(rst_n[0]), .psel(psel[0]), .penable(penable[0]),
        .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]),
        .prdata(prdata_o[0]), .pready(pready_o[0]), .pslverr(pslverr_o[0]),
        .ctrl_out(ctrl_o[0]), .wr_pulse(wr_pulse_o[0])
    );

    apb_regfile_slave #(.NUM_REGS(NREG), .WAIT_STATES(WS1)) u_dut1 (
        .clk(clk), .reset_n(rst_n[1]), .psel(psel[1]), .penable(penable[1]),
        .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]),
        .prdata(prdata_o[1]), .pready(pready_o[1]), .pslverr(pslverr_o[1]),
        .ctrl_out(ctrl_o[1]), .wr_pulse(wr_pulse_o[1])
    );

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got 0x%08h, expected 0x%08h (cycle %0d)", nm, d, act, exp, cyc);
        end
    endtask

    function automatic int ws_of(input int d);
        return (d == 0) ? WS0 : WS1;
    endfunction

    // Reference model: decide the outcome from the address rules alone.
    task automatic expect_xfer(input int d, input logic wr, input logic [31:0] a,
                               input logic [31:0] w, input int t0);
        logic        err;
        logic [31:0] data;
        int          idx;
        err  = (a[1:0] != 2'b00) || ((a >> 2) >= 32'(NREG));
        idx  = int'(a >> 2);
        data = 32'h0;
        if (!wr && !err) data = mem[d][idx];
        rq.push_back('{d, t0 + 1 + ws_of(d), data, err});
        if (wr && !err) begin
            mem[d][idx] = w;
            pq.push_back('{d, t0 + 2 + ws_of(d), mem[d][0]});
        end
    endtask

    task automatic idle(input int d, input int n);
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Full transfer. During the access phase the bus fields are scrambled;
    // the slave must ignore that. psel stays high on return so that the
    // caller may start a back-to-back setup in this very cycle.
    task automatic xfer(input int d, input logic wr, input logic [31:0] a, input logic [31:0] w);
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = w;
        expect_xfer(d, wr, a, w, cyc);
        @(posedge clk); #1;
        penable[d] = 1'b1;
        pwdata[d]  = 32'hFFFF_FFFF;
        paddr[d]   = a ^ 32'h0000_0004;
        pwrite[d]  = ~wr;
        repeat (ws_of(d) + 1) begin @(posedge clk); #1; end
    endtask

    task automatic readback(input int d);
        for (int i = 0; i < NREG; i++) xfer(d, 1'b0, 32'(i) << 2, 32'h0);
        idle(d, 1);
    endtask

    task automatic clear_model(input int d);
        for (int i = 0; i < NREG; i++) mem[d][i] = 32'h0;
    endtask

    task automatic random_phase(input int d, input int n);
        logic [31:0] a;
        int          r;
        for (int k = 0; k < n; k++) begin
            r = int'($urandom_range(0, 15));
            if (r < 10)      a = 32'(r) << 2;
            else if (r < 13) a = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(1, 3));
            else             a = $urandom;
            xfer(d, 1'($urandom_range(0, 1)), a, $urandom);
            r = int'($urandom_range(0, 2));
            if (r != 0) idle(d, r);
        end
        idle(d, 1);
    endtask

    // Monitor: compares each instance every cycle against queued expectations.
    always @(negedge clk) begin : mon
        logic exp_rdy;
        logic exp_pls;
        for (int d = 0; d < 2; d++) begin
            if (rst_n[d] == 1'b0) begin
                ctrl_exp[d] = 32'h0;
                while (rq.size() > 0 && rq[0].d == d) void'(rq.pop_front());
                while (pq.size() > 0 && pq[0].d == d) void'(pq.pop_front());
            end
            while (rq.size() > 0 && rq[0].d == d && rq[0].cyc < cyc) begin
                n_vec++; n_err++;
                $display("FAIL rsp_timeout dut%0d: got no pready, expected pready in cycle %0d", d, rq[0].cyc);
                void'(rq.pop_front());
            end
            while (pq.size() > 0 && pq[0].d == d && pq[0].cyc < cyc) begin
                n_vec++; n_err++;
                $display("FAIL pulse_timeout dut%0d: got no wr_pulse, expected wr_pulse in cycle %0d", d, pq[0].cyc);
                void'(pq.pop_front());
            end
            exp_rdy = (rq.size() > 0) && (rq[0].d == d) && (rq[0].cyc == cyc);
            chk("pready", d, 32'(pready_o[d]), 32'(exp_rdy));
            if (exp_rdy) begin
                chk("prdata", d, prdata_o[d], rq[0].data);
                chk("pslverr", d, 32'(pslverr_o[d]), 32'(rq[0].err));
                void'(rq.pop_front());
            end else begin
                chk("prdata_idle", d, prdata_o[d], 32'h0);
                chk("pslverr_idle", d, 32'(pslverr_o[d]), 32'h0);
            end
            exp_pls = (pq.size() > 0) && (pq[0].d == d) && (pq[0].cyc == cyc);
            if (exp_pls) begin
                ctrl_exp[d] = pq[0].ctrl;
                void'(pq.pop_front());
            end
            chk("wr_pulse", d, 32'(wr_pulse_o[d]), 32'(exp_pls));
            chk("ctrl_out", d, ctrl_o[d], ctrl_exp[d]);
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b1; psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
            paddr[d] = 32'h0; pwdata[d] = 32'h0; ctrl_exp[d] = 32'h0;
            clear_model(d);
        end
        #1;
        rst_n[0] = 1'b0; rst_n[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        @(posedge clk); #1;

        // ---------------- zero wait states ----------------
        xfer(0, 1'b0, 32'h04, 32'h0);            idle(0, 1);
        xfer(0, 1'b1, 32'h00, 32'hDEAD_BEEF);    idle(0, 1);
        xfer(0, 1'b0, 32'h00, 32'h0);            idle(0, 1);
        xfer(0, 1'b1, 32'h20, 32'hA5A5_A5A5);    idle(0, 1);
        xfer(0, 1'b0, 32'h02, 32'h0);            idle(0, 1);
        xfer(0, 1'b1, 32'h00, 32'h0000_0011);
        xfer(0, 1'b0, 32'h00, 32'h0);            idle(0, 2);

        // psel dropped in READY: pready still shows, but nothing commits.
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
        paddr[0] = 32'h0C; pwdata[0] = 32'h77;
        rq.push_back('{0, cyc + 1, 32'h0, 1'b0});
        @(posedge clk); #1;
        idle(0, 3);
        xfer(0, 1'b0, 32'h0C, 32'h0);            idle(0, 1);

        // Reset asserted while pready is high: outputs clear at once.
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
        paddr[0] = 32'h08; pwdata[0] = 32'h55;
        @(posedge clk); #1;
        chk("pready_before_reset", 0, 32'(pready_o[0]), 32'h1);
        rst_n[0] = 1'b0;
        #1;
        chk("pready_async_reset", 0, 32'(pready_o[0]), 32'h0);
        chk("ctrl_async_reset", 0, ctrl_o[0], 32'h0);
        chk("wr_pulse_async_reset", 0, 32'(wr_pulse_o[0]), 32'h0);
        clear_model(0);
        psel[0] = 1'b0; penable[0] = 1'b0;
        @(posedge clk); #1;
        rst_n[0] = 1'b1;
        @(posedge clk); #1;
        xfer(0, 1'b0, 32'h08, 32'h0);            idle(0, 1);

        random_phase(0, 60);
        readback(0);

        // ---------------- three wait states ----------------
        xfer(1, 1'b1, 32'h00, 32'hCAFE_0001);    idle(1, 1);
        xfer(1, 1'b1, 32'h1C, 32'h1234_5678);    idle(1, 1);
        xfer(1, 1'b0, 32'h1C, 32'h0);            idle(1, 1);
        xfer(1, 1'b1, 32'h20, 32'hA5A5_A5A5);
        xfer(1, 1'b0, 32'h02, 32'h0);            idle(1, 1);

        // psel dropped in the first wait cycle: no pready, no write.
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 32'h08; pwdata[1] = 32'h55;
        @(posedge clk); #1;
        idle(1, 6);
        xfer(1, 1'b0, 32'h08, 32'h0);            idle(1, 1);

        // Reset pulsed in T2 of a write: outputs clear at once, nothing commits.
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 32'h08; pwdata[1] = 32'h55;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        @(posedge clk); #1;
        rst_n[1] = 1'b0;
        #1;
        chk("ctrl_async_reset", 1, ctrl_o[1], 32'h0);
        chk("pready_async_reset", 1, 32'(pready_o[1]), 32'h0);
        chk("prdata_async_reset", 1, prdata_o[1], 32'h0);
        clear_model(1);
        psel[1] = 1'b0; penable[1] = 1'b0;
        @(posedge clk); #1;
        rst_n[1] = 1'b1;
        @(posedge clk); #1;
        xfer(1, 1'b0, 32'h08, 32'h0);            idle(1, 1);

        random_phase(1, 40);
        readback(1);

        idle(0, 2);
        idle(1, 4);
        chk("rsp_queue_drained", 0, 32'(rq.size()), 32'h0);
        chk("pulse_queue_drained", 0, 32'(pq.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected completion within 500000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/apb_regfile_slave.md
# apb_regfile_slave

APB completer that terminates transfers from the team's `apb_master` on a bank of 32-bit read/write registers. It decodes word-aligned addresses, inserts a fixed, parameterised number of wait states, and signals `pslverr` on bad addresses. Register 0 is also driven out as a control word, and a one-cycle pulse flags every committed write, so downstream logic can use the bank directly.

## Interface
- `NUM_REGS`, 8: number of 32-bit registers, valid range 1..256.
- `WAIT_STATES`, 0: wait cycles inserted per transfer, valid range 0..15.
- `clk` input 1: single clock; all logic samples on the rising edge.
- `reset_n` input 1: reset, asynchronous and active-low.
- `psel` input 1: slave select.
- `penable` input 1: access phase.
- `pwrite` input 1: 1 = write, 0 = read.
- `paddr` input 32: byte address.
- `pwdata` input 32: write data.
- `prdata` output 32: read data; valid while `pready`=1.
- `pready` output 1: transfer completes in this cycle.
- `pslverr` output 1: error response; valid while `pready`=1.
- `ctrl_out` output 32: current value of register 0.
- `wr_pulse` output 1: one-cycle pulse, the cycle after a write commits.

## Operation
- Decode:
  - index = `paddr[31:2]`.
  - The access is an error if `paddr[1:0]`≠0 or index ≥ `NUM_REGS`.
- FSM states:
  - IDLE to WAIT: on `psel`=1 and `penable`=0 (setup phase). Latch address, `pwrite`, `pwdata` and the error flag; load the wait counter with `WAIT_STATES`.
  - WAIT to READY: when the counter reaches 0, decrementing once per cycle. With `WAIT_STATES`=0, the FSM goes directly from IDLE to READY at the setup edge.
  - READY to IDLE: unconditional after one cycle. The transfer completes at this edge.
- In READY, `pready`=1 and `pslverr` = the latched error flag.
  - Read, no error: `prdata` = reg[index].
  - Read with error: `prdata` = 0.
  - Write: `prdata` = 0.
- A write commits at the clock edge that ends READY, only if `pwrite`=1 and there is no error. `wr_pulse` is high during the following cycle.
- An errored write leaves every register unchanged and produces no `wr_pulse`.
- Abort: if `psel` falls while in WAIT or READY, return to IDLE next edge with no write and no pulse.
- The slave uses its latched address and data; changes on `paddr`, `pwdata` or `pwrite` during the access phase are ignored.
- Back-to-back transfers: a setup phase seen in the cycle right after READY is accepted. There is no dead cycle beyond APB's mandatory setup phase.
- Reset values:
  - All registers 0, `ctrl_out` 0, `prdata` 0.
  - `pready` 0, `pslverr` 0, `wr_pulse` 0.
  - FSM in IDLE, counter 0.
- Reset asserted mid-transfer returns everything to the reset values immediately (asynchronous), and no write commits.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- Setup phase in cycle T0; access phase starts in T1.
- `pready`=1 only in cycle T1+`WAIT_STATES`; 0 in all other cycles.
- Total transfer length is 2+`WAIT_STATES` cycles, including setup.
- The register write is visible from cycle T2+`WAIT_STATES`: on `ctrl_out` when index is 0, and to any following read. `wr_pulse` is high in the same cycle.
- `prdata` and `pslverr` return to 0 the cycle after `pready`.

## Test plan
- Reset then read: release `reset_n`, then read address 0x04 → `prdata`=0x00000000, `pslverr`=0, `pready` high exactly in T1 (`WAIT_STATES`=0).
- Write/read-back: write 0xDEADBEEF to 0x00, then read 0x00 → `ctrl_out`=0xDEADBEEF from T2, `wr_pulse` high for 1 cycle, read returns 0xDEADBEEF.
- Wait states: with `WAIT_STATES`=3, write 0x12345678 to 0x1C → `pready` low T1–T3 and high T4. A changed `pwdata` of 0xFFFFFFFF during T2 is ignored; read of 0x1C returns 0x12345678.
- Errors:
  - Write 0xA5A5A5A5 to 0x20 (`NUM_REGS`=8) → `pslverr`=1 with `pready`, no `wr_pulse`, all registers unchanged.
  - Read 0x02 → `pslverr`=1, `prdata`=0.
- Abort and reset:
  - `WAIT_STATES`=2, write 0x55 to 0x08, drop `psel` in T1 → no `pready`, reg2 stays 0.
  - Repeat with `reset_n` pulsed low in T2 → all outputs 0 asynchronously, reg2 stays 0.
- Back-to-back: write 0x11 to 0x00, with the next setup phase (read 0x00) in the cycle after `pready` → read returns 0x00000011 with `pready` in its T1.
